// File: rtl/pipe_out_block_arbiter.sv
// rtl/pipe_out_block_arbiter.sv - round-robin whole-block arbiter for a shared 16-bit pipe-out endpoint
// Optional: define PIPE_ARB_PRIORITY0_EN to give source 0 strict priority over the round-robin scan.
module pipe_out_block_arbiter #(
  parameter int N_SRC       = 4,
  parameter int BLOCK_WORDS = 256,
  parameter int LVL_W       = 11
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [N_SRC*LVL_W-1:0]       src_level,
  input  logic [N_SRC*16-1:0]          src_data,
  output logic [N_SRC-1:0]             src_rd,
  output logic                         ep_ready,
  input  logic                         ep_blockstrobe,
  input  logic                         ep_read,
  output logic [15:0]                  ep_datain,
  output logic [$clog2(N_SRC)-1:0]     grant_id,
  output logic [15:0]                  blk_count,
  output logic                         proto_err
);

  localparam int GW = $clog2(N_SRC);
  localparam int CW = $clog2(BLOCK_WORDS) + 1;
  localparam logic [LVL_W-1:0] BLK_LVL = LVL_W'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_READY,
    S_XFER,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   ptr_q;
  logic [CW-1:0]   word_cnt;
  logic            arb_hit;
  logic [GW-1:0]   arb_sel;
  logic            rd_ok;
  logic            rd_bad;
  logic [LVL_W-1:0] lvl [N_SRC];
  logic [15:0]      dat [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign lvl[g] = src_level[g*LVL_W +: LVL_W];
    assign dat[g] = src_data[g*16 +: 16];
  end

  // Scan starts just after the last served source, so it is considered last.
  always_comb begin
    int idx;
    arb_hit = 1'b0;
    arb_sel = '0;
    idx     = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(ptr_q) + k) % N_SRC;
      if (!arb_hit && lvl[idx] >= BLK_LVL) begin
        arb_hit = 1'b1;
        arb_sel = GW'(idx);
      end
    end
`ifdef PIPE_ARB_PRIORITY0_EN
    if (lvl[0] >= BLK_LVL) begin
      arb_hit = 1'b1;
      arb_sel = '0;
    end
`else
`endif
  end

  always_comb begin
    state_d = state_q;
    rd_ok   = 1'b0;
    src_rd  = '0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_ARB;
      end
      S_ARB: begin
        if (!enable)      state_d = S_IDLE;
        else if (arb_hit) state_d = S_READY;
      end
      S_READY: begin
        // A word already taken by the endpoint commits the block even if enable falls.
        if (ep_read) begin
          rd_ok   = 1'b1;
          state_d = S_XFER;
        end else if (!enable) begin
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        if (ep_read) begin
          rd_ok = 1'b1;
          if (word_cnt == LAST_WORD) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = enable ? S_ARB : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rd_ok) src_rd[grant_id] = 1'b1;
  end

  assign rd_bad = ep_read && (state_q == S_IDLE || state_q == S_ARB || state_q == S_DRAIN);

  always_comb begin
    ep_datain = 16'h0000;
    if (state_q == S_READY || state_q == S_XFER || state_q == S_DRAIN) begin
      ep_datain = dat[grant_id];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= GW'(N_SRC - 1);
      grant_id  <= '0;
      word_cnt  <= '0;
      blk_count <= 16'h0000;
      proto_err <= 1'b0;
      ep_ready  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ep_ready <= (state_q == S_READY) && (state_d == S_READY);
      if (state_q == S_ARB) begin
        word_cnt <= '0;
        if (state_d == S_READY) grant_id <= arb_sel;
      end
      if (rd_ok) word_cnt <= word_cnt + CW'(1);
      if (state_q == S_DRAIN) begin
        blk_count <= blk_count + 16'd1;
        ptr_q     <= grant_id;
      end
      if (rd_bad) proto_err <= 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ep_blockstrobe;

endmodule

// File: tb/tb_pipe_out_block_arbiter.sv
// tb/tb_pipe_out_block_arbiter.sv - randomized self-checking bench for pipe_out_block_arbiter
module tb_pipe_out_block_arbiter;

  localparam int N  = 4;
  localparam int BW = 256;
  localparam int LW = 11;
  localparam int GW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [N*LW-1:0]   src_level;
  logic [N*16-1:0]   src_data;
  logic [N-1:0]      src_rd;
  logic              ep_ready;
  logic              ep_blockstrobe;
  logic              ep_read;
  logic [15:0]       ep_datain;
  logic [GW-1:0]     grant_id;
  logic [15:0]       blk_count;
  logic              proto_err;

  int tests = 0;
  int fails = 0;
  int fifo_cnt [N];
  int m_cnt [N];
  int lvl [N];
  int m_ptr;
  int m_blk;
  logic [15:0] salt;

  pipe_out_block_arbiter #(.N_SRC(N), .BLOCK_WORDS(BW), .LVL_W(LW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .src_level      (src_level),
    .src_data       (src_data),
    .src_rd         (src_rd),
    .ep_ready       (ep_ready),
    .ep_blockstrobe (ep_blockstrobe),
    .ep_read        (ep_read),
    .ep_datain      (ep_datain),
    .grant_id       (grant_id),
    .blk_count      (blk_count),
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int s, input int n);
    logic [15:0] v;
    v = {s[3:0], 12'(n)};
    return v ^ salt;
  endfunction

  // Winner = qualifying source closest after the last served one, going around.
  function automatic int exp_grant();
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (lvl[i] >= BW) begin
        d = (i - m_ptr - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
`ifdef PIPE_ARB_PRIORITY0_EN
    if (lvl[0] >= BW) best = 0;
`endif
    return best;
  endfunction

  task automatic set_levels();
    for (int i = 0; i < N; i++) src_level[i*LW +: LW] = LW'(lvl[i]);
  endtask

  task automatic model_reset();
    m_ptr = N - 1;
    m_blk = 0;
  endtask

  // One clock: drive at posedge+1, sample mid-cycle, source FIFOs return data after the edge.
  task automatic step(input logic rd, output logic [N-1:0] r, output logic [15:0] d, output logic rdy);
    ep_read = rd;
    #2;
    r   = src_rd;
    d   = ep_datain;
    rdy = ep_ready;
    @(posedge clk);
    #1;
    ep_read        = 1'b0;
    ep_blockstrobe = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        src_data[i*16 +: 16] = pat(i, fifo_cnt[i]);
        fifo_cnt[i]++;
      end
    end
  endtask

  task automatic wait_ready();
    logic [N-1:0] r;
    logic [15:0]  d;
    logic         rdy;
    int           n;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 12) begin
      step(1'b0, r, d, rdy);
      chk("wait_src_rd", 32'(r), 32'(0));
      n++;
    end
    chk("ready_seen", 32'(rdy), 32'(1));
  endtask

  task automatic read_block(input int drop_at);
    logic [N-1:0] r, exp_r;
    logic [15:0]  d, last;
    logic         rdy, have;
    int           src, gaps;
    src   = exp_grant();
    exp_r = '0;
    exp_r[src] = 1'b1;
    wait_ready();
    chk("grant_id", 32'(grant_id), 32'(src));
    ep_blockstrobe = 1'b1;
    step(1'b0, r, d, rdy);
    chk("strobe_ready", 32'(rdy), 32'(1));
    chk("strobe_src_rd", 32'(r), 32'(0));
    have = 1'b0;
    last = 16'h0;
    for (int w = 0; w < BW; w++) begin
      if (w == drop_at) enable = 1'b0;
      gaps = ($urandom_range(5) == 0) ? $urandom_range(1, 3) : 0;
      for (int g = 0; g < gaps; g++) begin
        step(1'b0, r, d, rdy);
        chk("gap_src_rd", 32'(r), 32'(0));
        if (have) chk("gap_hold_data", 32'(d), 32'(last));
      end
      step(1'b1, r, d, rdy);
      chk("src_rd", 32'(r), 32'(exp_r));
      if (have) chk("ep_datain", 32'(d), 32'(last));
      last = pat(src, m_cnt[src]);
      m_cnt[src]++;
      have = 1'b1;
    end
    step(1'b0, r, d, rdy);
    chk("drain_src_rd", 32'(r), 32'(0));
    chk("drain_data", 32'(d), 32'(last));
    m_blk++;
    m_ptr = src;
    chk("blk_count", 32'(blk_count), 32'(m_blk & 16'hffff));
    chk("grant_hold", 32'(grant_id), 32'(src));
  endtask

  initial begin
    logic [N-1:0] r;
    logic [15:0]  d;
    logic         rdy;
    logic [N-1:0] one1;
    int           any;

    reset_n = 1'b0;
    enable = 1'b0;
    ep_read = 1'b0;
    ep_blockstrobe = 1'b0;
    src_level = '0;
    src_data = '0;
    salt = 16'($urandom);
    for (int i = 0; i < N; i++) begin
      fifo_cnt[i] = 0;
      m_cnt[i] = 0;
      lvl[i] = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ep_ready), 32'(0));
    chk("rst_src_rd", 32'(src_rd), 32'(0));
    chk("rst_grant", 32'(grant_id), 32'(0));
    chk("rst_blk", 32'(blk_count), 32'(0));
    chk("rst_perr", 32'(proto_err), 32'(0));
    chk("rst_data", 32'(ep_datain), 32'(0));
    reset_n = 1'b1;

    // Nothing qualifies: arbiter keeps scanning, endpoint never sees ready.
    enable = 1'b1;
    set_levels();
    for (int c = 0; c < 10; c++) begin
      step(1'b0, r, d, rdy);
      chk("empty_ready", 32'(rdy), 32'(0));
      chk("empty_src_rd", 32'(r), 32'(0));
      chk("empty_data", 32'(d), 32'(0));
    end
    step(1'b1, r, d, rdy);
    chk("arb_read_src_rd", 32'(r), 32'(0));
    step(1'b0, r, d, rdy);
    chk("proto_err_set", 32'(proto_err), 32'(1));
    chk("arb_read_blk", 32'(blk_count), 32'(0));

    lvl[2] = 256;
    set_levels();
    read_block(-1);
    chk("proto_err_sticky", 32'(proto_err), 32'(1));

    // Reset in the middle of a block.
    lvl[2] = 0;
    lvl[1] = 256;
    set_levels();
    wait_ready();
    chk("mid_grant", 32'(grant_id), 32'(exp_grant()));
    one1 = '0;
    one1[1] = 1'b1;
    for (int w = 0; w < 50; w++) begin
      step(1'b1, r, d, rdy);
      chk("mid_src_rd", 32'(r), 32'(one1));
      m_cnt[1]++;
    end
    ep_read = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_src_rd", 32'(src_rd), 32'(0));
    chk("arst_ready", 32'(ep_ready), 32'(0));
    chk("arst_grant", 32'(grant_id), 32'(0));
    chk("arst_blk", 32'(blk_count), 32'(0));
    chk("arst_perr", 32'(proto_err), 32'(0));
    chk("arst_data", 32'(ep_datain), 32'(0));
    ep_read = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();

    // Everyone full: rotation from source 0.
    for (int i = 0; i < N; i++) lvl[i] = 512;
    set_levels();
    for (int b = 0; b < 4; b++) read_block(-1);

    // Enable dropped mid-block: block completes, then arbiter idles.
    read_block(100);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, r, d, rdy);
      chk("off_ready", 32'(rdy), 32'(0));
      chk("off_src_rd", 32'(r), 32'(0));
    end
    enable = 1'b1;

    // Enable dropped while ready: no grant consumed.
    lvl[0] = 100;
    lvl[3] = 700;
    set_levels();
    wait_ready();
    enable = 1'b0;
    step(1'b0, r, d, rdy);
    step(1'b0, r, d, rdy);
    chk("abort_ready", 32'(rdy), 32'(0));
    chk("abort_blk", 32'(blk_count), 32'(m_blk & 16'hffff));
    enable = 1'b1;
    read_block(-1);

    // Random levels.
    for (int b = 0; b < 5; b++) begin
      any = 0;
      for (int i = 0; i < N; i++) begin
        lvl[i] = ($urandom_range(1) == 1) ? $urandom_range(BW, 2047) : $urandom_range(0, BW - 1);
        if (lvl[i] >= BW) any = 1;
      end
      if (any == 0) lvl[$urandom_range(N - 1)] = BW;
      set_levels();
      read_block(-1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pipe_out_block_arbiter.md
Name: pipe_out_block_arbiter

Overview:
- Shares one block-throttled 16-bit pipe-out endpoint among N_SRC data sources, typically FIFOs filled by capture logic on the host-interface clock.
- Grants one whole block at a time using round-robin, only to a source holding at least BLOCK_WORDS words.
- Drives the endpoint ready flag, steers per-word read strobes to the granted source, and muxes its data onto the endpoint.
- Sits between the endpoint and the source FIFOs; clocked by the host-interface clock.

Parameters:
- N_SRC, 4: number of sources (2..8).
- BLOCK_WORDS, 256: 16-bit words per block (power of 2, 2..1024).
- LVL_W, 11: width of each source level input; must be able to represent BLOCK_WORDS.

Ports:
- clk  in  1  host-interface clock; all logic is on this one clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  arbitration enable, from a control wire.
- src_level  in  N_SRC*LVL_W  words available in each source; source i occupies slice [i*LVL_W +: LVL_W].
- src_data  in  N_SRC*16  read data per source; 1-cycle read latency.
- src_rd  out  N_SRC  per-source read strobe; one-hot or zero.
- ep_ready  out  1  to the endpoint: a full block is available.
- ep_blockstrobe  in  1  endpoint block-start pulse.
- ep_read  in  1  endpoint word-read strobe.
- ep_datain  out  16  data to the endpoint.
- grant_id  out  clog2(N_SRC)  currently or last granted source.
- blk_count  out  16  blocks completed; wraps.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, and the round-robin pointer is N_SRC-1, so source 0 is checked first.
- FSM states: IDLE, ARB, READY, XFER, DRAIN.
- IDLE: ep_ready=0. Goes to ARB when enable=1.
- ARB (1 cycle per evaluation):
  - Scan sources ptr+1, ptr+2, ... with wrap-around.
  - The first source with src_level >= BLOCK_WORDS is latched into grant_id; next state is READY.
  - If no source qualifies, stay in ARB.
  - If enable=0, go to IDLE.
- READY:
  - ep_ready is registered and goes to 1 on the cycle after entering READY.
  - The first ep_read moves the FSM to XFER, counts that word, and drops ep_ready to 0 on the next cycle.
  - ep_blockstrobe alone does not change state.
  - enable=0 while in READY (no word read yet): drop ep_ready and go to IDLE with no grant consumed.
- XFER:
  - src_rd[grant_id] = ep_read, combinationally; all other src_rd bits are 0.
  - The word counter (width clog2(BLOCK_WORDS)+1) increments on each ep_read.
  - When the counter reaches BLOCK_WORDS, go to DRAIN.
  - enable=0 during XFER does not abort: the block completes first.
- DRAIN (1 cycle):
  - Holds the mux so the final word is delivered.
  - Increments blk_count (0xFFFF wraps to 0) and sets ptr=grant_id.
  - Next state is ARB if enable=1, else IDLE.
- ep_datain:
  - Equals src_data[grant_id] in READY, XFER and DRAIN, giving the 1-cycle latency after ep_read.
  - Equals 0 otherwise.
- grant_id is stable from ARB exit through DRAIN.
- Protocol errors:
  - ep_read in IDLE, ARB or DRAIN sets proto_err.
  - Such a read produces no src_rd and is not counted.
  - proto_err clears only on reset.
- src_level is sampled only in ARB; changes during a block are ignored.
- Fairness: a source that was just served is checked last on the next ARB.
- Reset asserted mid-block returns everything to the reset state immediately; a partially drained FIFO is the system's concern.

Optional Feature:
- Macro: PIPE_ARB_PRIORITY0_EN.
- Defined: source 0 has strict priority. If its level >= BLOCK_WORDS in ARB it wins regardless of ptr; the remaining sources are scanned round-robin as above.
- Undefined: pure round-robin, with no logic for the priority path.

Test Plan:
- Reset, then enable=1 with all levels 0: ep_ready stays 0, FSM remains in ARB, src_rd=0, blk_count=0.
- Level[2]=256, others 0: grant_id=2 and ep_ready=1 within 3 cycles. 256 ep_reads -> exactly 256 src_rd[2] pulses; ep_datain on cycle t+1 equals src_data[2]; blk_count=1.
- All levels=512, four blocks read: grant order 0,1,2,3, blk_count=4. With PIPE_ARB_PRIORITY0_EN defined: order 0,0,0,0.
- enable dropped after word 100 of a block: the remaining 156 reads are still served, blk_count increments, then FSM goes to IDLE with ep_ready=0.
- ep_read pulse in ARB: proto_err=1, no src_rd, word count unaffected. proto_err stays 1 until reset_n=0.
- reset_n pulsed low at word 50: all outputs 0 asynchronously. After release, source 0 is checked first.
